// File: rtl/seq_stream_sched.sv
// Round-robin scheduler that shares one a(n) = a(n-3) + a(n-2) engine among requesters,
// fast-forwards it to each window's start index and streams the window with an id tag.
module seq_stream_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 16,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*IDX_W-1:0] req_start_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_data_o,
  output logic [ID_W-1:0]          out_id_o,
  output logic                     out_last_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {StIdle, StSkip, StStream} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [IDX_W-1:0]  skip_q, skip_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       t3_q, t2_q, t1_q;
  logic [31:0]       t3_d, t2_d, t1_d;

  logic [IDX_W-1:0]  start_arr [NUM_REQ];
  logic [LEN_W-1:0]  len_arr [NUM_REQ];
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   rr_idx;
  logic              eng_load;
  logic              eng_adv;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      start_arr[i] = req_start_i[i*IDX_W +: IDX_W];
      len_arr[i]   = req_len_i[i*LEN_W +: LEN_W];
    end
  end

  // First pending requester at or after the pointer, searching circularly.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid_i[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    skip_d   = skip_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    eng_load = 1'b0;
    eng_adv  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          eng_load = 1'b1;
          id_d     = gnt_idx;
          len_d    = len_arr[gnt_idx];
          ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (len_arr[gnt_idx] == '0) begin
            state_d = StIdle;
          end else if (start_arr[gnt_idx] != '0) begin
            skip_d  = start_arr[gnt_idx];
            state_d = StSkip;
          end else begin
            cnt_d   = len_arr[gnt_idx];
            state_d = StStream;
          end
        end
      end
      StSkip: begin
        eng_adv = 1'b1;
        skip_d  = skip_q - IDX_W'(1);
        if (skip_q == IDX_W'(1)) begin
          cnt_d   = len_q;
          state_d = StStream;
        end
      end
      StStream: begin
        if (out_ready_i) begin
          eng_adv = 1'b1;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    t3_d = t3_q;
    t2_d = t2_q;
    t1_d = t1_q;
    if (eng_load) begin
      t3_d = 32'd0;
      t2_d = 32'd1;
      t1_d = 32'd1;
    end else if (eng_adv) begin
      t3_d = t2_q;
      t2_d = t1_q;
      t1_d = t3_q + t2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      skip_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      t3_q    <= 32'd0;
      t2_q    <= 32'd1;
      t1_q    <= 32'd1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      t3_q    <= t3_d;
      t2_q    <= t2_d;
      t1_q    <= t1_d;
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && gnt_found) req_ready_o[gnt_idx] = 1'b1;
  end

  assign out_valid_o = (state_q == StStream);
  assign out_last_o  = (state_q == StStream) && (cnt_q == LEN_W'(1));
  assign out_data_o  = t3_q;
  assign out_id_o    = id_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_seq_stream_sched.sv
// Directed bench for seq_stream_sched: hand-computed windows, round-robin order, stalls,
// zero-length requests and reset in mid-window.
module tb_seq_stream_sched;

  localparam int unsigned NumReq = 4;
  localparam int unsigned IdxW   = 16;
  localparam int unsigned LenW   = 16;
  localparam int unsigned IdW    = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NumReq-1:0]      req_valid;
  logic [NumReq-1:0]      req_ready;
  logic [NumReq*IdxW-1:0] req_start;
  logic [NumReq*LenW-1:0] req_len;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;
  logic [IdW-1:0]         out_id;
  logic                   out_last;
  logic                   busy;

  int total = 0;
  int bad   = 0;

  seq_stream_sched #(
    .NUM_REQ(NumReq),
    .IDX_W  (IdxW),
    .LEN_W  (LenW),
    .ID_W   (IdW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_start_i(req_start),
    .req_len_i  (req_len),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_id_o   (out_id),
    .out_last_o (out_last),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] start, input logic [15:0] len);
    req_valid[i]             = 1'b1;
    req_start[i*IdxW +: IdxW] = start;
    req_len[i*LenW +: LenW]   = len;
  endtask

  logic [31:0] exp_a [6]  = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2};
  logic [31:0] exp_b [4]  = '{32'd7, 32'd9, 32'd12, 32'd16};
  logic [31:0] exp_rr [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
  logic        rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] exp_st [6] = '{32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
  logic        last_st [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int          stray;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_start = '0;
    req_len   = '0;
    out_ready = 1'b1;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    reset = 1'b0;
    step();

    // Window 0..5 from requester 0.
    set_req(0, 16'd0, 16'd6);
    #1;
    check("t1_req_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_data", out_data, exp_a[k]);
      check("t1_last", 32'(out_last), (k == 5) ? 32'd1 : 32'd0);
      check("t1_id", 32'(out_id), 32'd0);
      step();
    end
    check("t1_valid_after", 32'(out_valid), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Skip 9 terms then stream a(9..12).
    set_req(1, 16'd9, 16'd4);
    #1;
    check("t2_req_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    stray = 0;
    for (int k = 0; k < 9; k++) begin
      if (out_valid !== 1'b0) stray++;
      step();
    end
    check("t2_skip_quiet", 32'(stray), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_data", out_data, exp_b[k]);
      check("t2_last", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
      check("t2_id", 32'(out_id), 32'd1);
      step();
    end
    check("t2_valid_after", 32'(out_valid), 32'd0);

    // Reset pointer, then all four request len=1 continuously.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) set_req(i, 16'd0, 16'd1);
    #1;
    for (int g = 0; g < 5; g++) begin
      check("t3_grant", 32'(req_ready), 32'd1 << exp_rr[g]);
      step();
      check("t3_no_ready_busy", 32'(req_ready), 32'd0);
      check("t3_data", out_data, 32'd0);
      check("t3_last", 32'(out_last), 32'd1);
      check("t3_id", 32'(out_id), exp_rr[g]);
      step();
    end
    req_valid = '0;
    step();

    // Stalled stream of a(3..5); pointer now at 1, only requester 2 asks.
    set_req(2, 16'd3, 16'd3);
    #1;
    check("t4_req_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    stray = 0;
    for (int k = 0; k < 3; k++) begin
      if (out_valid !== 1'b0) stray++;
      step();
    end
    check("t4_skip_quiet", 32'(stray), 32'd0);
    for (int k = 0; k < 6; k++) begin
      out_ready = rdy_pat[k];
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_data", out_data, exp_st[k]);
      check("t4_last", 32'(out_last), 32'(last_st[k]));
      check("t4_id", 32'(out_id), 32'd2);
      step();
    end
    out_ready = 1'b1;
    check("t4_valid_after", 32'(out_valid), 32'd0);

    // Zero-length request is consumed without output and can be regranted at once.
    set_req(3, 16'd0, 16'd0);
    #1;
    check("t5_req_ready", 32'(req_ready), 32'b1000);
    step();
    check("t5_no_valid", 32'(out_valid), 32'd0);
    check("t5_not_busy", 32'(busy), 32'd0);
    check("t5_regrant", 32'(req_ready), 32'b1000);
    req_valid = '0;
    step();
    check("t5_no_valid2", 32'(out_valid), 32'd0);

    // Reset four terms into a len=10 window; pointer must restart at 0.
    set_req(0, 16'd0, 16'd10);
    #1;
    check("t6_req_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      check("t6_data", out_data, exp_a[k]);
      step();
    end
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    step();
    set_req(0, 16'd0, 16'd2);
    set_req(1, 16'd0, 16'd2);
    #1;
    check("t6_ptr_zero", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      check("t6_post_valid", 32'(out_valid), 32'd1);
      check("t6_post_data", out_data, exp_a[k]);
      check("t6_post_last", 32'(out_last), (k == 1) ? 32'd1 : 32'd0);
      check("t6_post_id", 32'(out_id), 32'd0);
      step();
    end
    check("t6_post_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_stream_sched.md
Name: seq_stream_sched

Overview:
Scheduler that shares one embedded recurrence engine among NUM_REQ requesters. The engine computes a(n) = a(n-3) + a(n-2) mod 2^32, with seeds a0=0, a1=1, a2=1. Each requester asks for a window of terms (start index, length). The scheduler arbitrates round-robin, fast-forwards the engine to the start index, and streams the window out on a valid/ready port tagged with the requester id. It sits between software-visible request queues and a shared result bus.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
IDX_W, 16, width of start index
LEN_W, 16, width of window length
ID_W, $clog2(NUM_REQ), width of requester id

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request pending
req_ready  out  NUM_REQ  one-hot accept pulse; request i is consumed when req_valid[i] && req_ready[i]
req_start  in  NUM_REQ*IDX_W  packed start indices; slice i = [i*IDX_W +: IDX_W]
req_len  in  NUM_REQ*LEN_W  packed window lengths
out_valid  out  1  output term valid
out_ready  in  1  downstream accept
out_data  out  32  current term a(n)
out_id  out  ID_W  requester id of current window
out_last  out  1  final term of window
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE; RR pointer=0.
  - req_ready, out_valid, out_last, busy all 0; out_data=0; out_id=0.
  - Engine regs (t3,t2,t1) = (0,1,1).
- Engine:
  - out_data = t3.
  - Advance: t3<=t2, t2<=t1, t1<=t3+t2 (32-bit, wrap, carry dropped).
- States: IDLE, SKIP, STREAM.
- IDLE:
  - If any req_valid, pick the first set bit at or after the RR pointer (circular). req_ready[g] is combinational from req_valid and the pointer, and is high only in IDLE.
  - On grant: latch start, len and id=g; load engine seeds (0,1,1); pointer<=g+1 mod NUM_REQ.
  - Next state: len==0 -> IDLE (request consumed, no output); start>0 -> SKIP with skip_cnt=start; else STREAM with cnt=len.
  - No request pending -> stay in IDLE.
- SKIP:
  - Advance engine once per cycle; skip_cnt--.
  - When skip_cnt reaches 0 (after start advances), go to STREAM with cnt=len.
  - out_valid=0 throughout.
- STREAM:
  - out_valid=1; out_id=latched id; out_last=(cnt==1).
  - On handshake: advance engine, cnt--; if cnt was 1 -> IDLE, out_valid deasserts next cycle.
  - Stall (out_ready=0): out_data, out_id, out_last held stable; engine frozen.
- Latency:
  - Grant at cycle G → first out_valid at G+1+start.
  - Minimum gap between windows is one IDLE cycle.
- No new grant while busy. req_valid changes during SKIP/STREAM are ignored; inputs are sampled only at grant.
- Fairness: a continuously requesting set is served strictly in circular order. No requester waits more than NUM_REQ-1 windows.
- Reset mid-window: window abandoned with no out_last; after release, state is IDLE with pointer 0.
- Max window: start=2^IDX_W-1, len=2^LEN_W-1. Counters do not overflow.

Test Plan:
- Single req0 start=0 len=6, out_ready=1 -> out_data 0,1,1,1,2,2 on consecutive cycles; out_last on 6th term; out_id=0; busy drops after.
- req1 start=9 len=4 -> 9 cycles with no out_valid, then 7,9,12,16; last on 16; first valid at grant+10.
- All four req_valid held high, each len=1 start=0 -> grants in order 0,1,2,3,0; each window outputs 0 with out_last=1; req_ready is one-hot.
- req2 start=3 len=3, out_ready toggling 1,0,0,1,0,1 -> accepted sequence 1,2,2; data, id and last stable during stalls; no duplicated or dropped terms.
- len=0 on req3 -> req_ready[3] pulses once; no out_valid; immediately regrantable the next IDLE cycle.
- Assert reset during STREAM of len=10 after 4 terms -> outputs zero immediately; after release, req0 start=0 len=2 yields 0,1.
